uart_rx_os: RTL and testbench

- Standalone 16x-oversampling UART receiver. It sits between the serial pin and a byte-stream consumer, such as the AXI register block or a FIFO.
- Adds majority-vote sampling, false-start rejection, framing-error detection and a one-entry valid/ready output holding register with overrun flag.
- It is the receiving end of 8N1 serial frames as produced by the team's UART transmitter and bench stimulus tasks.

---
 rtl/uart_rx_os.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_os.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// 16x-oversampling 8N1 UART receiver.
// The serial input is synchronized, then sampled three times around each bit
// centre and decided by majority vote. Completed bytes go into a one-entry
// valid/ready holding register. Framing errors and overruns raise sticky flags.
module uart_rx_os #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int TICK_DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err,
  output logic       busy
);

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  // Sample points inside a bit: three ticks around the centre, and the last tick.
  localparam logic [3:0]    S_SAMP_A  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    S_SAMP_B  = 4'(OVERSAMPLE / 2);
  localparam logic [3:0]    S_DECIDE  = 4'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0]    S_LAST    = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state_reg;
  logic [1:0]    sync_reg;
  logic          rx_s;
  logic          rx_prev_reg;
  logic [1:0]    fill_reg;
  logic [TW-1:0] tick_cnt_reg;
  logic [3:0]    s_cnt_reg;
  logic [1:0]    samp_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          tick;
  logic          fall_edge;
  logic          start_det;
  logic          maj;
  logic          at_decide;
  logic          at_last;

  // Two-flop synchronizer chain, idle-high after reset.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First stage captures the raw asynchronous pin.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) sync_reg[gi] <= 1'b1;
          else     sync_reg[gi] <= rx;
        end
      end else begin : g_rest
        // Later stages re-register the previous stage.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) sync_reg[gi] <= 1'b1;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign rx_s = sync_reg[1];

  // Edge history. The fill counter makes sure the reset value of the
  // synchronizer is never taken for a real high level, so a line that is
  // already low when reset is released is not seen as a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev_reg <= 1'b1;
      fill_reg    <= 2'd0;
    end else begin
      rx_prev_reg <= rx_s;
      if (fill_reg != 2'd3) fill_reg <= fill_reg + 2'd1;
    end
  end

  assign fall_edge = (fill_reg == 2'd3) && rx_prev_reg && !rx_s;
  assign start_det = (state_reg == IDLE) && fall_edge;
  assign tick      = (tick_cnt_reg == TICK_LAST);
  assign at_decide = tick && (s_cnt_reg == S_DECIDE);
  assign at_last   = tick && (s_cnt_reg == S_LAST);
  assign maj       = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_s) | (samp_reg[1] & rx_s);

  // Free-running tick divider, re-phased to the start-bit edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  tick_cnt_reg <= '0;
    else if (start_det || tick) tick_cnt_reg <= '0;
    else                      tick_cnt_reg <= tick_cnt_reg + 1'b1;
  end

  // Sample counter within a bit plus the first two majority samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cnt_reg <= 4'd0;
      samp_reg  <= 2'b00;
    end else begin
      if (start_det)  s_cnt_reg <= 4'd0;
      else if (tick)  s_cnt_reg <= s_cnt_reg + 4'd1;
      if (tick && (s_cnt_reg == S_SAMP_A)) samp_reg[0] <= rx_s;
      if (tick && (s_cnt_reg == S_SAMP_B)) samp_reg[1] <= rx_s;
    end
  end

  // Frame state machine with the holding register and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'h00;
      data_out    <= 8'h00;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Consumer handshake; a load below overrides this clear.
      if (valid && ready) valid <= 1'b0;
      // Clear first so a same-cycle set below wins.
      if (clr_err) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (fall_edge) begin
            state_reg <= START;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (at_decide && maj) begin
            // Line came back high by mid start bit: a glitch, not a frame.
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else if (at_last) begin
            state_reg   <= DATA;
            bit_idx_reg <= 3'd0;
          end
        end
        DATA: begin
          if (at_decide) shift_reg <= {maj, shift_reg[7:1]};
          if (at_last) begin
            if (bit_idx_reg == 3'd7) state_reg <= STOP;
            else                     bit_idx_reg <= bit_idx_reg + 3'd1;
          end
        end
        STOP: begin
          // Decide mid stop bit so an immediately following start bit is caught.
          if (at_decide) begin
            if (maj) begin
              if (!valid || ready) begin
                data_out <= shift_reg;
                valid    <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state_reg <= IDLE;
              busy      <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state_reg <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed scenarios plus randomized
// frames, checked against a queue of bytes the receiver must deliver.
module tb_uart_rx_os;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       clr_err;
  logic       busy;

  int n_compared   = 0;
  int n_mismatched = 0;
  int n_beats      = 0;
  int cyc          = 0;
  int rise_cyc     = 0;
  logic prev_valid = 1'b0;

  // Reference model: bytes that must appear on the output, in order.
  logic [7:0] exp_q[$];

  uart_rx_os dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clr_err   (clr_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  // Output monitor: every transfer must match the head of the model queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && !prev_valid) rise_cyc = cyc;
      if (valid && ready) begin
        n_beats++;
        check_val("beat_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) begin
          $display("beat %0d: data_out=0x%02h want=0x%02h", n_beats, data_out, exp_q[0]);
          check_val("beat_data", {24'd0, data_out}, {24'd0, exp_q[0]});
          void'(exp_q.pop_front());
        end
      end
      prev_valid = valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: cycles=%0d limit=150000", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bclk);
    rx = 1'b0;
    wait_clks(bclk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(bclk);
    end
    rx = stop_bit;
    wait_clks(bclk);
    rx = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    wait_clks(1);
    clr_err = 1'b0;
    wait_clks(1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 6000) begin
      wait_clks(1);
      n++;
    end
    check_val(tag, exp_q.size(), 0);
  endtask

  initial begin
    int start_cyc;
    int lat;
    logic [7:0] b;
    int bc;
    int gap;
    logic bad;

    rst = 1'b1; rx = 1'b1; ready = 1'b0; clr_err = 1'b0;
    wait_clks(4);
    check_val("rst_data", {24'd0, data_out}, 32'h0);
    check_val("rst_valid", valid, 0);
    check_val("rst_ferr", frame_err, 0);
    check_val("rst_ovr", overrun, 0);
    check_val("rst_busy", busy, 0);
    rst = 1'b0;
    ready = 1'b1;
    wait_clks(10);

    // Basic byte with latency check (nominal 4161 clocks, +/- one tick).
    exp_q.push_back(8'hB4);
    start_cyc = cyc;
    send_frame(8'hB4, 1'b1, 434);
    lat = rise_cyc - start_cyc;
    $display("basic: valid latency %0d clocks", lat);
    check_val("basic_latency", (lat >= 4134 && lat <= 4188) ? 32'd1 : 32'd0, 32'd1);
    drain("basic_drain");
    check_val("basic_ferr", frame_err, 0);
    check_val("basic_ovr", overrun, 0);
    check_val("basic_busy", busy, 0);
    check_val("basic_valid_low", valid, 0);
    wait_clks(50);

    // Back-to-back frames, no idle gap.
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hA3);
    send_frame(8'h55, 1'b1, 434);
    send_frame(8'hA3, 1'b1, 434);
    drain("b2b_drain");
    check_val("b2b_ferr", frame_err, 0);
    check_val("b2b_ovr", overrun, 0);
    wait_clks(50);

    // Short low glitch must be rejected as a false start.
    rx = 1'b0;
    wait_clks(100);
    rx = 1'b1;
    wait_clks(400);
    check_val("glitch_busy", busy, 0);
    check_val("glitch_valid", valid, 0);
    check_val("glitch_ferr", frame_err, 0);
    check_val("glitch_ovr", overrun, 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 434);
    drain("glitch_next");
    wait_clks(50);

    // Framing error, then clear and resend.
    send_frame(8'h3C, 1'b0, 434);
    wait_clks(20);
    check_val("ferr_set", frame_err, 1);
    check_val("ferr_valid", valid, 0);
    check_val("ferr_busy", busy, 0);
    pulse_clr();
    check_val("ferr_clr", frame_err, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 434);
    drain("ferr_next");
    wait_clks(50);

    // Overrun: second byte dropped while the first is held.
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 434);
    send_frame(8'h22, 1'b1, 434);
    wait_clks(20);
    check_val("ovr_valid", valid, 1);
    check_val("ovr_data", {24'd0, data_out}, 32'h11);
    check_val("ovr_flag", overrun, 1);
    check_val("ovr_ferr", frame_err, 0);
    ready = 1'b1;
    wait_clks(1);
    ready = 1'b0;
    wait_clks(1);
    check_val("ovr_drain", exp_q.size(), 0);
    check_val("ovr_valid_low", valid, 0);
    pulse_clr();
    check_val("ovr_clr", overrun, 0);
    ready = 1'b1;
    wait_clks(50);

    // Reset during data bit 4 of 0xF0 (a high bit).
    rx = 1'b0;
    wait_clks(434);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      wait_clks(434);
    end
    rx = 1'b1;
    wait_clks(200);
    check_val("mid_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check_val("mid_data", {24'd0, data_out}, 32'h0);
    check_val("mid_valid", valid, 0);
    check_val("mid_busy", busy, 0);
    check_val("mid_ferr", frame_err, 0);
    check_val("mid_ovr", overrun, 0);
    wait_clks(5);
    rst = 1'b0;
    wait_clks(20);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, 434);
    drain("mid_next");
    wait_clks(50);

    // Randomized frames with varied bit period, gaps and stop-bit errors.
    for (int i = 0; i < 4; i++) begin
      b   = 8'($urandom_range(0, 255));
      bc  = $urandom_range(428, 438);
      bad = (i == 1) || ($urandom_range(0, 4) == 0);
      if (!bad) exp_q.push_back(b);
      $display("rand %0d: byte=0x%02h bitclks=%0d stop_ok=%0d", i, b, bc, !bad);
      send_frame(b, !bad, bc);
      gap = bad ? $urandom_range(40, 200) : $urandom_range(0, 200);
      if (gap > 0) wait_clks(gap);
      check_val("rand_ferr", frame_err, bad);
      check_val("rand_ovr", overrun, 0);
      if (bad) begin
        pulse_clr();
        check_val("rand_ferr_clr", frame_err, 0);
      end
    end
    drain("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
